// File: rtl/thor2024_fpu_dispatch_pkg.sv
// Thor2024pkg: shared instruction types and opcodes for the Thor2024 core,
// plus the entry record held by the FPU dispatch queue.
//
// Contents:
//   r2_instr_t           - register-register instruction field view
//   instruction_t        - 32-bit instruction (r2 view or raw bits)
//   OP_FLT2 / OP_FLT3    - floating-point opcodes routed to the FPUs
//   FPU_DISPATCH_TAGW    - storage width of the reorder tag in an entry
//   fpu_dispatch_entry_t - one queued instruction plus its reorder tag
//   is_fpu_op()          - opcode classifier used by the dispatcher
package Thor2024pkg;

  localparam logic [6:0] OP_FLT2 = 7'h4C;
  localparam logic [6:0] OP_FLT3 = 7'h4D;

  // The dispatcher stores tags at this width; its TAGW parameter must not exceed it.
  localparam int FPU_DISPATCH_TAGW = 8;

  typedef struct packed {
    logic [6:0] func;
    logic [5:0] rs2;
    logic [5:0] rs1;
    logic [5:0] rd;
    logic [6:0] opcode;
  } r2_instr_t;

  typedef union packed {
    r2_instr_t   r2;
    logic [31:0] raw;
  } instruction_t;

  typedef struct packed {
    instruction_t                 instr;
    logic [FPU_DISPATCH_TAGW-1:0] tag;
  } fpu_dispatch_entry_t;

  function automatic logic is_fpu_op(input logic [6:0] op);
    return (op == OP_FLT2) || (op == OP_FLT3);
  endfunction

endpackage

// File: rtl/thor2024_fpu_dispatch_sel.sv
// thor2024_fpu_dispatch_sel: maps the oldest queue entries onto ready units.
// The k-th lowest-index ready unit receives the k-th oldest entry, as long
// as k is below the queue occupancy.
//
// Ports:
//   count      in   current queue occupancy
//   fu_ready   in   per-unit ready
//   sel_valid  out  per-unit "this unit gets an entry"
//   sel_offset out  per-unit entry offset from the queue head (valid only
//                   where sel_valid is set)
module thor2024_fpu_dispatch_sel #(
  parameter int NFPU = 2,
  parameter int CW   = 4,
  parameter int OW   = 1
) (
  input  logic [CW-1:0]             count,
  input  logic [NFPU-1:0]           fu_ready,
  output logic [NFPU-1:0]           sel_valid,
  output logic [NFPU-1:0][OW-1:0]   sel_offset
);

  // rank = number of entries already handed to lower-index units. It never
  // exceeds count, so CW bits always hold it.
  logic [CW-1:0] w_rank;

  always_comb begin
    w_rank     = '0;
    sel_valid  = '0;
    sel_offset = '0;
    for (int i = 0; i < NFPU; i++) begin
      sel_offset[i] = w_rank[OW-1:0];
      if (fu_ready[i] && (w_rank < count)) begin
        sel_valid[i] = 1'b1;
        w_rank       = w_rank + CW'(1);
      end
    end
  end

endmodule

// File: rtl/thor2024_fpu_dispatch.sv
// thor2024_fpu_dispatch: in-order issue queue feeding up to NFPU floating
// point units. OP_FLT2/OP_FLT3 instructions are queued with their reorder
// tag; each cycle the oldest entries go to the lowest-index ready units.
//
// Handshake: a transfer on either side happens in a cycle where valid and
// ready are both high at the clock edge. in_ready comes from registered
// occupancy only (no credit for same-cycle dispatch). fu_valid may depend
// combinationally on fu_ready; units must not make fu_ready depend on
// fu_valid.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard all queued entries at the next edge
//   in_valid/in_instr/in_tag  offered instruction and reorder tag
//   in_ready            queue has space (count < DEPTH)
//   in_fpu              offered opcode is OP_FLT2 or OP_FLT3
//   fu_valid/fu_instr/fu_tag  per-unit issue
//   fu_ready            per-unit accept
//   count               current occupancy
//   stat_issued/stat_stall    only with THOR2024_FPU_DISPATCH_STATS_EN:
//                       saturating totals of transfers and of cycles where
//                       the queue held entries but nothing transferred
//
// Configuration macro: THOR2024_FPU_DISPATCH_STATS_EN
module thor2024_fpu_dispatch
  import Thor2024pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NFPU  = 2,
  parameter int TAGW  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  instruction_t                 in_instr,
  input  logic [TAGW-1:0]              in_tag,
  output logic                         in_ready,
  output logic                         in_fpu,
  output logic [NFPU-1:0]              fu_valid,
  output instruction_t [NFPU-1:0]      fu_instr,
  output logic [NFPU-1:0][TAGW-1:0]    fu_tag,
  input  logic [NFPU-1:0]              fu_ready,
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_stall,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = (NFPU > 1) ? $clog2(NFPU) : 1;

  fpu_dispatch_entry_t r_mem [DEPTH];
  logic [AW-1:0]       r_head;
  logic [AW-1:0]       r_tail;
  logic [CW-1:0]       r_count;

  logic                      w_enq;
  logic [CW-1:0]             w_ndisp;
  logic [NFPU-1:0]           w_sel_valid;
  logic [NFPU-1:0][OW-1:0]   w_sel_offset;

  assign in_fpu   = is_fpu_op(in_instr.r2.opcode);
  assign in_ready = (r_count < CW'(DEPTH));
  assign count    = r_count;
  assign w_enq    = in_valid & in_fpu & in_ready & ~flush;

  thor2024_fpu_dispatch_sel #(
    .NFPU (NFPU),
    .CW   (CW),
    .OW   (OW)
  ) u_sel (
    .count      (r_count),
    .fu_ready   (fu_ready),
    .sel_valid  (w_sel_valid),
    .sel_offset (w_sel_offset)
  );

  assign fu_valid = w_sel_valid;

  // Read port per unit: head plus offset, wrapping naturally since DEPTH is
  // a power of two.
  for (genvar g = 0; g < NFPU; g++) begin : g_unit
    logic [AW-1:0] w_idx;
    assign w_idx       = r_head + AW'(w_sel_offset[g]);
    assign fu_instr[g] = r_mem[w_idx].instr;
    assign fu_tag[g]   = r_mem[w_idx].tag[TAGW-1:0];
  end

  always_comb begin
    w_ndisp = '0;
    for (int i = 0; i < NFPU; i++) begin
      w_ndisp = w_ndisp + CW'(fu_valid[i] & fu_ready[i]);
    end
  end

  // Storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_tail].instr <= in_instr;
      r_mem[r_tail].tag   <= FPU_DISPATCH_TAGW'(in_tag);
    end
  end

  // Transfers during a flush cycle are real, but the pointers are zeroed
  // anyway, so flush simply overrides the normal update.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_ndisp);
      r_tail  <= r_tail + AW'(w_enq);
      r_count <= r_count + CW'(w_enq) - w_ndisp;
    end
  end

`ifdef THOR2024_FPU_DISPATCH_STATS_EN
  logic [32:0] w_issued_sum;
  assign w_issued_sum = {1'b0, stat_issued} + 33'(w_ndisp);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      stat_issued <= w_issued_sum[32] ? '1 : w_issued_sum[31:0];
      if ((r_count != '0) && (w_ndisp == '0) && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_thor2024_fpu_dispatch.sv
module tb_thor2024_fpu_dispatch;
  import Thor2024pkg::*;

  localparam int DEPTH = 8;
  localparam int NFPU  = 2;
  localparam int TAGW  = 5;

  // ---------------- clock / reset / signals ----------------
  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      in_valid;
  instruction_t              in_instr;
  logic [TAGW-1:0]           in_tag;
  logic                      in_ready;
  logic                      in_fpu;
  logic [NFPU-1:0]           fu_valid;
  instruction_t [NFPU-1:0]   fu_instr;
  logic [NFPU-1:0][TAGW-1:0] fu_tag;
  logic [NFPU-1:0]           fu_ready;
  logic [3:0]                count;
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
  logic [31:0]               stat_issued;
  logic [31:0]               stat_stall;
`endif

  always #5 clk = ~clk;

  thor2024_fpu_dispatch #(.DEPTH(DEPTH), .NFPU(NFPU), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .in_ready    (in_ready),
    .in_fpu      (in_fpu),
    .fu_valid    (fu_valid),
    .fu_instr    (fu_instr),
    .fu_tag      (fu_tag),
    .fu_ready    (fu_ready),
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
`endif
    .count       (count)
  );

  // ---------------- scoreboard ----------------
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  armed    = 1'b0;

  // Each queued item is {instruction bits, tag}, oldest at the front.
  logic [31+TAGW:0] exp_q[$];
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
  logic [31:0] m_issued = '0;
  logic [31:0] m_stall  = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of items. On each cycle the ready units, in index
  // order, take the oldest items; then the edge pops those, and either
  // empties the FIFO (rst/flush) or appends an accepted FPU instruction.
  always @(negedge clk) begin : compare
    int k;
    logic [NFPU-1:0] ev;
    bit is_fpu, enq;
    is_fpu = (in_instr.r2.opcode == OP_FLT2) || (in_instr.r2.opcode == OP_FLT3);
    k  = 0;
    ev = '0;
    if (armed) begin
      chk("count", count, exp_q.size());
      chk("in_ready", in_ready, exp_q.size() < DEPTH);
      chk("in_fpu", in_fpu, is_fpu);
    end
    for (int i = 0; i < NFPU; i++) begin
      if (fu_ready[i] && k < exp_q.size()) begin
        ev[i] = 1'b1;
        if (armed) begin
          chk($sformatf("fu_tag%0d", i), fu_tag[i], exp_q[k][TAGW-1:0]);
          chk($sformatf("fu_instr%0d", i), fu_instr[i].raw, exp_q[k][31+TAGW:TAGW]);
        end
        k++;
      end
    end
    if (armed) chk("fu_valid", fu_valid, ev);
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
    if (armed) begin
      chk("stat_issued", stat_issued, m_issued);
      chk("stat_stall", stat_stall, m_stall);
    end
`endif
    enq = in_valid && is_fpu && (exp_q.size() < DEPTH) && !flush;
    if (rst) begin
      exp_q.delete();
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
      m_issued = '0;
      m_stall  = '0;
`endif
    end else begin
`ifdef THOR2024_FPU_DISPATCH_STATS_EN
      m_issued = m_issued + 32'(k);
      if (exp_q.size() > 0 && k == 0) m_stall = m_stall + 1;
`endif
      repeat (k) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (enq) exp_q.push_back({in_instr.raw, in_tag});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [6:0] op, input logic [TAGW-1:0] tag,
                       input logic [NFPU-1:0] rdy, input bit fl, input bit r);
    in_valid           = v;
    in_instr.raw       = $urandom;
    in_instr.r2.opcode = op;
    in_tag             = tag;
    fu_ready           = rdy;
    flush              = fl;
    rst                = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] op;
    drive(0, 7'h01, 0, '0, 0, 1);
    cyc();
    armed = 1'b1;
    cyc();
    drive(0, 7'h01, 0, '0, 0, 0);

    // Reset state
    peek();
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fu_valid", fu_valid, 2'b00);
    cyc();

    // Three FLT instructions, dispatched in order
    drive(1, OP_FLT2, 5'd1, 2'b11, 0, 0);
    peek(); chk("t27_empty_valid", fu_valid, 2'b00); cyc();
    drive(1, OP_FLT2, 5'd2, 2'b11, 0, 0);
    peek(); chk("t27_first_valid", fu_valid, 2'b01); chk("t27_first_tag", fu_tag[0], 1); cyc();
    drive(1, OP_FLT3, 5'd3, 2'b00, 0, 0);
    peek(); chk("t27_hold_valid", fu_valid, 2'b00); cyc();
    drive(0, OP_FLT2, 5'd0, 2'b11, 0, 0);
    peek();
    chk("t27_pair_valid", fu_valid, 2'b11);
    chk("t27_pair_tag0", fu_tag[0], 2);
    chk("t27_pair_tag1", fu_tag[1], 3);
    chk("t27_pair_count", count, 2);
    cyc();
    peek(); chk("t27_drained", count, 0); cyc();

    // Non-FPU opcodes are ignored
    for (int i = 0; i < 10; i++) begin
      drive(1, 7'h01, 5'(i), 2'($urandom_range(0, 3)), 0, 0);
      peek();
      chk("t28_in_fpu", in_fpu, 0);
      chk("t28_count", count, 0);
      chk("t28_fu_valid", fu_valid, 2'b00);
      cyc();
    end

    // Fill to full, then a single ready unit on index 1
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, OP_FLT2, 5'(10 + i), 2'b00, 0, 0);
      cyc();
    end
    drive(1, OP_FLT3, 5'd30, 2'b00, 0, 0);
    peek(); chk("t29_full_count", count, 8); chk("t29_full_ready", in_ready, 0); cyc();
    drive(0, OP_FLT2, 5'd0, 2'b10, 0, 0);
    peek(); chk("t29_unit1_valid", fu_valid, 2'b10); chk("t29_unit1_tag", fu_tag[1], 10); cyc();
    drive(0, OP_FLT2, 5'd0, 2'b00, 0, 0);
    peek(); chk("t29_after_count", count, 7); chk("t29_after_ready", in_ready, 1); cyc();
    drive(0, OP_FLT2, 5'd0, 2'b11, 0, 0);
    repeat (4) cyc();

    // Simultaneous enqueue and double dispatch
    for (int i = 0; i < 4; i++) begin
      drive(1, OP_FLT2, 5'(20 + i), 2'b00, 0, 0);
      cyc();
    end
    drive(1, OP_FLT2, 5'd24, 2'b11, 0, 0);
    peek(); chk("t30_pre_count", count, 4); chk("t30_pre_valid", fu_valid, 2'b11); cyc();
    drive(0, OP_FLT2, 5'd0, 2'b00, 0, 0);
    peek(); chk("t30_post_count", count, 3); cyc();

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_FLT2;
        1:       op = OP_FLT3;
        2:       op = OP_FLT2;
        default: op = 7'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, op, 5'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 39) == 0, 0);
      cyc();
    end
    drive(0, OP_FLT2, 5'd0, 2'b00, 1, 0);
    cyc();

    // Flush with a concurrent FPU offer
    for (int i = 0; i < 5; i++) begin
      drive(1, OP_FLT3, 5'(i), 2'b00, 0, 0);
      cyc();
    end
    drive(1, OP_FLT2, 5'd7, 2'b11, 1, 0);
    peek(); chk("t31_flush_valid", fu_valid, 2'b11); chk("t31_flush_count", count, 5); cyc();
    drive(0, OP_FLT2, 5'd0, 2'b11, 0, 0);
    peek(); chk("t31_flushed_count", count, 0); chk("t31_flushed_valid", fu_valid, 2'b00); cyc();

    // Reset on top of flush and enqueue
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_FLT2, 5'(i), 2'b00, 0, 0);
      cyc();
    end
    drive(1, OP_FLT2, 5'd9, 2'b11, 1, 1);
    cyc();
    drive(0, OP_FLT2, 5'd0, 2'b11, 0, 0);
    peek();
    chk("t31_rst_count", count, 0);
    chk("t31_rst_ready", in_ready, 1);
    chk("t31_rst_valid", fu_valid, 2'b00);
    cyc();

`ifdef THOR2024_FPU_DISPATCH_STATS_EN
    // Statistics start from the reset above: 4 stalled cycles, 3 transfers
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_FLT2, 5'(i), 2'b00, 0, 0);
      cyc();
    end
    drive(0, OP_FLT2, 5'd0, 2'b00, 0, 0);
    repeat (2) cyc();
    drive(0, OP_FLT2, 5'd0, 2'b01, 0, 0);
    repeat (3) cyc();
    drive(0, OP_FLT2, 5'd0, 2'b00, 0, 0);
    peek(); chk("t32_stall", stat_stall, 4); chk("t32_issued", stat_issued, 3); cyc();
`endif

    drive(0, OP_FLT2, 5'd0, 2'b00, 0, 0);
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
